// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding sequencer for a 5-stage pipeline.
// Handles load-use and branch hazards, freezes the pipe while a data-RAM
// access is outstanding, selects EX operand forwarding, and records a sticky
// bus-timeout error.
// Optional feature: define PERF_CNT_EN to build saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 8,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_rR1,
  input  logic [4:0]        ID_rR2,
  input  logic              ID_re1,
  input  logic              ID_re2,
  input  logic [4:0]        EX_wR,
  input  logic              EX_rf_we,
  input  logic              EX_is_load,
  input  logic              EX_br_taken,
  input  logic [4:0]        MEM_wR,
  input  logic              MEM_rf_we,
  input  logic [4:0]        WB_wR,
  input  logic              WB_rf_we,
  input  logic              MEM_req,
  input  logic              mem_ack,
  output logic              pc_stall,
  output logic              IFID_stall,
  output logic              IDEX_stall,
  output logic              EXMEM_stall,
  output logic              IFID_flush,
  output logic              IDEX_flush,
  output logic              MEMWB_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_err,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_count
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt;
  logic             set_err;
  logic             load_use;

  // Load-use: EX load writes a register that the ID instruction actually reads.
  assign load_use = EX_is_load && EX_rf_we && (EX_wR != 5'd0) &&
                    ((ID_re1 && (ID_rR1 == EX_wR)) || (ID_re2 && (ID_rR2 == EX_wR)));

  // Operand forwarding select: MEM beats WB beats RF; x0 is never forwarded.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    fwd_a = 2'd0;
    fwd_b = 2'd0;
    if (rst) begin
      if (ID_re1 && ID_rR1 != 5'd0 && MEM_rf_we && MEM_wR == ID_rR1)     fwd_a = 2'd1;
      else if (ID_re1 && ID_rR1 != 5'd0 && WB_rf_we && WB_wR == ID_rR1)  fwd_a = 2'd2;
      if (ID_re2 && ID_rR2 != 5'd0 && MEM_rf_we && MEM_wR == ID_rR2)     fwd_b = 2'd1;
      else if (ID_re2 && ID_rR2 != 5'd0 && WB_rf_we && WB_wR == ID_rR2)  fwd_b = 2'd2;
    end
  end

  // Next-state and stall/flush decode from state plus current hazards.
  always_comb begin
    pc_stall    = 1'b0;
    IFID_stall  = 1'b0;
    IDEX_stall  = 1'b0;
    EXMEM_stall = 1'b0;
    IFID_flush  = 1'b0;
    IDEX_flush  = 1'b0;
    MEMWB_flush = 1'b0;
    next_state  = state;
    next_cnt    = wait_cnt;
    set_err     = 1'b0;
    if (!rst) begin
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      MEMWB_flush = 1'b1;
      next_state  = RUN;
      next_cnt    = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (MEM_req && !mem_ack) begin
            pc_stall    = 1'b1;
            IFID_stall  = 1'b1;
            IDEX_stall  = 1'b1;
            EXMEM_stall = 1'b1;
            MEMWB_flush = 1'b1;
            next_state  = MEM_WAIT;
            next_cnt    = CNT_W'(1);
          end else if (EX_br_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
          end else if (load_use) begin
            pc_stall   = 1'b1;
            IFID_stall = 1'b1;
            IDEX_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          // EX is frozen here, so branch and load-use are re-evaluated after exit.
          if (mem_ack) begin
            next_state = RUN;
            next_cnt   = '0;
          end else if (wait_cnt == CNT_W'(MEM_TIMEOUT)) begin
            MEMWB_flush = 1'b1;
            set_err     = 1'b1;
            next_state  = RUN;
            next_cnt    = '0;
          end else begin
            pc_stall    = 1'b1;
            IFID_stall  = 1'b1;
            IDEX_stall  = 1'b1;
            EXMEM_stall = 1'b1;
            MEMWB_flush = 1'b1;
            if (wait_cnt != '1) next_cnt = wait_cnt + CNT_W'(1);
          end
        end
        default: next_state = RUN;
      endcase
    end
  end

  // State, wait counter and sticky error register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (set_err) mem_err <= 1'b1;
    end
  end

`ifdef PERF_CNT_EN
  // Saturating performance counters, held at zero during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + PERF_W'(1);
      if ((IFID_flush || IDEX_flush) && flush_count != '1)
        flush_count <= flush_count + PERF_W'(1);
    end
  end
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: single-cycle hazard/forwarding
// vector table followed by multi-cycle sequences for memory wait, timeout,
// suppressed branches, reset mid-wait and the performance counters.
module tb_pipe_hazard_ctrl;

  localparam int PERF_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [4:0]        ID_rR1, ID_rR2, EX_wR, MEM_wR, WB_wR;
  logic              ID_re1, ID_re2, EX_rf_we, EX_is_load, EX_br_taken;
  logic              MEM_rf_we, WB_rf_we, MEM_req, mem_ack;
  logic              pc_stall, IFID_stall, IDEX_stall, EXMEM_stall;
  logic              IFID_flush, IDEX_flush, MEMWB_flush, mem_err;
  logic [1:0]        fwd_a, fwd_b;
  logic [PERF_W-1:0] stall_cycles, flush_count;
  logic [10:0]       outs;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst),
    .ID_rR1(ID_rR1), .ID_rR2(ID_rR2), .ID_re1(ID_re1), .ID_re2(ID_re2),
    .EX_wR(EX_wR), .EX_rf_we(EX_rf_we), .EX_is_load(EX_is_load), .EX_br_taken(EX_br_taken),
    .MEM_wR(MEM_wR), .MEM_rf_we(MEM_rf_we), .WB_wR(WB_wR), .WB_rf_we(WB_rf_we),
    .MEM_req(MEM_req), .mem_ack(mem_ack),
    .pc_stall(pc_stall), .IFID_stall(IFID_stall), .IDEX_stall(IDEX_stall),
    .EXMEM_stall(EXMEM_stall), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .MEMWB_flush(MEMWB_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Packed view: {pc,IFID,IDEX,EXMEM stall, IFID,IDEX,MEMWB flush, fwd_a, fwd_b}
  assign outs = {pc_stall, IFID_stall, IDEX_stall, EXMEM_stall,
                 IFID_flush, IDEX_flush, MEMWB_flush, fwd_a, fwd_b};

  localparam logic [10:0] O_IDLE  = 11'b0000_000_00_00;
  localparam logic [10:0] O_LU    = 11'b1100_010_00_00;
  localparam logic [10:0] O_BR    = 11'b0000_110_00_00;
  localparam logic [10:0] O_WAIT  = 11'b1111_001_00_00;
  localparam logic [10:0] O_DROP  = 11'b0000_001_00_00;
  localparam logic [10:0] O_RESET = 11'b0000_111_00_00;

  typedef struct {
    logic [4:0]  rr1, rr2;
    logic        re1, re2;
    logic [4:0]  ex_wr;
    logic        ex_we, ex_load, br;
    logic [4:0]  mem_wr;
    logic        mem_we;
    logic [4:0]  wb_wr;
    logic        wb_we, req, ack;
    logic [10:0] exp;
  } vec_t;

  function automatic vec_t mk(int rr1, int rr2, int re1, int re2,
                              int ex_wr, int ex_we, int ex_load, int br,
                              int mem_wr, int mem_we, int wb_wr, int wb_we,
                              int req, int ack, logic [10:0] exp);
    vec_t v;
    v.rr1 = 5'(rr1);       v.rr2 = 5'(rr2);
    v.re1 = 1'(re1);       v.re2 = 1'(re2);
    v.ex_wr = 5'(ex_wr);   v.ex_we = 1'(ex_we);
    v.ex_load = 1'(ex_load); v.br = 1'(br);
    v.mem_wr = 5'(mem_wr); v.mem_we = 1'(mem_we);
    v.wb_wr = 5'(wb_wr);   v.wb_we = 1'(wb_we);
    v.req = 1'(req);       v.ack = 1'(ack);
    v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr();
    ID_rR1 = 0; ID_rR2 = 0; ID_re1 = 0; ID_re2 = 0;
    EX_wR = 0; EX_rf_we = 0; EX_is_load = 0; EX_br_taken = 0;
    MEM_wR = 0; MEM_rf_we = 0; WB_wR = 0; WB_rf_we = 0;
    MEM_req = 0; mem_ack = 0;
  endtask

  // Inputs are driven 1ns after posedge; outputs are checked at the negedge.
  task automatic settle();
    #4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0, O_IDLE);
    vecs[1]  = mk(5,0,1,0, 5,1,1,0, 0,0,0,0, 0,0, O_LU);
    vecs[2]  = mk(5,0,1,0, 0,0,0,0, 5,1,0,0, 0,0, 11'b0000_000_01_00);
    vecs[3]  = mk(0,3,0,1, 0,0,0,0, 3,1,3,1, 0,0, 11'b0000_000_00_01);
    vecs[4]  = mk(0,0,1,0, 0,0,0,0, 0,1,0,1, 0,0, O_IDLE);
    vecs[5]  = mk(7,7,1,1, 0,0,0,0, 0,0,7,1, 0,0, 11'b0000_000_10_10);
    vecs[6]  = mk(7,0,0,0, 0,0,0,0, 7,1,0,0, 0,0, O_IDLE);
    vecs[7]  = mk(7,0,1,0, 0,0,0,0, 7,0,7,1, 0,0, 11'b0000_000_10_00);
    vecs[8]  = mk(5,0,1,0, 5,1,1,1, 0,0,0,0, 0,0, O_BR);
    vecs[9]  = mk(0,0,1,0, 0,1,1,0, 0,0,0,0, 0,0, O_IDLE);
    vecs[10] = mk(5,5,0,1, 5,1,1,0, 0,0,0,0, 0,0, O_LU);
    vecs[11] = mk(5,0,1,0, 5,0,1,0, 0,0,0,0, 0,0, O_IDLE);
    vecs[12] = mk(0,0,0,0, 0,0,0,1, 0,0,0,0, 1,1, O_BR);
    vecs[13] = mk(5,0,1,0, 5,1,0,0, 0,0,0,0, 0,0, O_IDLE);
    vecs[14] = mk(4,9,1,1, 9,1,1,0, 4,1,9,1, 0,0, 11'b1100_010_01_10);
    vecs[15] = mk(0,0,0,0, 0,0,0,0, 0,0,0,0, 0,1, O_IDLE);

    clr();
    rst = 1'b0;
    tick();

    // Reset overrides hazards: stalls 0, flushes 1, forwarding 0.
    MEM_req = 1; EX_br_taken = 1; ID_rR1 = 3; ID_re1 = 1; MEM_wR = 3; MEM_rf_we = 1;
    settle();
    check("reset_outs", 32'(outs), 32'(O_RESET));
    check("reset_err", 32'(mem_err), 32'd0);
    check("reset_perf", stall_cycles | flush_count, 32'd0);
    tick();
    clr();
    rst = 1'b1;

    // Single-cycle table, all in RUN state.
    for (int i = 0; i < 16; i++) begin
      ID_rR1 = vecs[i].rr1;   ID_rR2 = vecs[i].rr2;
      ID_re1 = vecs[i].re1;   ID_re2 = vecs[i].re2;
      EX_wR = vecs[i].ex_wr;  EX_rf_we = vecs[i].ex_we;
      EX_is_load = vecs[i].ex_load; EX_br_taken = vecs[i].br;
      MEM_wR = vecs[i].mem_wr; MEM_rf_we = vecs[i].mem_we;
      WB_wR = vecs[i].wb_wr;  WB_rf_we = vecs[i].wb_we;
      MEM_req = vecs[i].req;  mem_ack = vecs[i].ack;
      settle();
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
      tick();
    end
    clr();

    // Wait with ack on the 4th cycle: 3 stall cycles, release on ack.
    MEM_req = 1;
    for (int c = 0; c < 3; c++) begin
      settle();
      check($sformatf("wait_stall%0d", c), 32'(outs), 32'(O_WAIT));
      tick();
    end
    mem_ack = 1;
    settle();
    check("wait_release", 32'(outs), 32'(O_IDLE));
    tick();
    clr();
    EX_br_taken = 1;
    settle();
    check("wait_back_run", 32'(outs), 32'(O_BR));
    tick();
    clr();

    // Timeout with MEM_TIMEOUT=4: 4 stall cycles, drop cycle, sticky error.
    MEM_req = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("to_stall%0d", c), 32'(outs), 32'(O_WAIT));
      tick();
    end
    settle();
    check("to_drop", 32'(outs), 32'(O_DROP));
    check("to_err_before", 32'(mem_err), 32'd0);
    tick();
    clr();
    mem_ack = 1;
    settle();
    check("to_err_set", 32'(mem_err), 32'd1);
    check("to_run", 32'(outs), 32'(O_IDLE));
    tick();
    mem_ack = 0;
    tick(); tick();
    settle();
    check("to_err_sticky", 32'(mem_err), 32'd1);
    tick();

    // Branch during wait is suppressed until after release; reset mid-wait.
    MEM_req = 1;
    settle();
    check("brw_enter", 32'(outs), 32'(O_WAIT));
    tick();
    EX_br_taken = 1;
    settle();
    check("brw_suppressed", 32'(outs), 32'(O_WAIT));
    tick();
    mem_ack = 1;
    settle();
    check("brw_release", 32'(outs), 32'(O_IDLE));
    tick();
    MEM_req = 0; mem_ack = 0;
    settle();
    check("brw_flush_after", 32'(outs), 32'(O_BR));
    tick();
    clr();
    MEM_req = 1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    check("rstw_outs", 32'(outs), 32'(O_RESET));
    tick();
    rst = 1'b1;
    MEM_req = 0;
    settle();
    check("rstw_run", 32'(outs), 32'(O_IDLE));
    check("rstw_err", 32'(mem_err), 32'd0);
    tick();

    // Perf: load-use (1 stall, 1 flush), 3-cycle wait (3 stalls), branch (1 flush).
    clr();
    do_reset();
    ID_rR1 = 5; ID_re1 = 1; EX_wR = 5; EX_rf_we = 1; EX_is_load = 1;
    settle();
    check("perf_lu", 32'(outs), 32'(O_LU));
    tick();
    EX_is_load = 0; EX_rf_we = 0; EX_wR = 0; MEM_wR = 5; MEM_rf_we = 1;
    settle();
    check("perf_lu_fwd", 32'(fwd_a), 32'd1);
    tick();
    clr();
    MEM_req = 1;
    tick(); tick(); tick();
    mem_ack = 1;
    tick();
    clr();
    EX_br_taken = 1;
    tick();
    clr();
    settle();
`ifdef PERF_CNT_EN
    check("perf_stall", stall_cycles, 32'd4);
    check("perf_flush", flush_count, 32'd2);
`else
    check("perf_stall_off", stall_cycles, 32'd0);
    check("perf_flush_off", flush_count, 32'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
